serial_adder: RTL

- Bit-serial, parametrised successor to the single-bit half/full adder cells.
- Reuses one full-adder datapath and a carry flip-flop to add or subtract two WIDTH-bit operands, LSB first, over WIDTH clock cycles.
- Uses a start/busy/done handshake and reports registered carry-out and signed overflow.
- Sits wherever area matters more than latency, for example a slow datapath accumulator.

---
 rtl/serial_adder.sv | 100 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder cell plus a carry flop, LSB first.
// Latency: WIDTH cycles from the accepting edge to the done pulse; one result per WIDTH+1 cycles.
// No backpressure: start is sampled only in IDLE/DONE and ignored while busy.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] res;      // upper result bits collected so far
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s;
    logic             c_next;
    logic [WIDTH-1:0] full;

    // Full-adder cell on the current LSBs; full is the result as it would stand after this bit
    always_comb begin
        s      = sa[0] ^ sb[0] ^ carry;
        c_next = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
        full   = {s, res};
    end

    // Control FSM, operand/result shift registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1; borrow-in flips the injected carry
                        sa    <= a;
                        sb    <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    carry <= c_next;
                    sa    <= {1'b0, sa[WIDTH-1:1]};
                    sb    <= {1'b0, sb[WIDTH-1:1]};
                    res   <= full[WIDTH-1:1];
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB here
                        sum   <= full;
                        cout  <= c_next;
                        ovf   <= carry ^ c_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
